// File: rtl/adc_sample_writer_pkg.sv
// adc_sample_writer_pkg: frame FSM encoding and sample-bank widths shared across the Goertzel path
package adc_sample_writer_pkg;
  localparam int SAMPLE_ADDR_W = 10;
  localparam int SAMPLE_IDX_W = 9;
  localparam int SAMPLE_W = 8;
  typedef enum logic [2:0] {ST_IDLE, ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD, ST_WRITE} frame_state_e;
endpackage

// File: rtl/adc_sample_writer_spi_frame_engine.sv
// spi_frame_engine: SPI mode-0 frame sequencer driving CS/SCK/MOSI and capturing MISO
module spi_frame_engine
  import adc_sample_writer_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int FRAME_BITS = 16,
  parameter logic [15:0] CMD_WORD = 16'h6000,
  parameter int SAMPLE_LSB = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic miso_i,
  output logic cs_o,
  output logic sck_o,
  output logic mosi_o,
  output logic busy_o,
  output logic done_o,
  output logic [SAMPLE_W-1:0] sample_o
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam int RX_W = SAMPLE_LSB + SAMPLE_W;
  localparam logic [FRAME_BITS-1:0] CMD = CMD_WORD[15 -: FRAME_BITS];
  frame_state_e state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [RX_W-1:0] rx_q, rx_d;
  logic sck_q, sck_d, cs_q, cs_d, mosi_q, mosi_d, miso_q;
  logic phase_end, start, rise, fall, done;
  always_comb begin
    phase_end = div_q == DIV_W'(CLK_DIV - 1);
    start = state_q == ST_IDLE && start_i;
    rise = state_q == ST_SHIFT && phase_end && !sck_q;
    fall = state_q == ST_SHIFT && phase_end && sck_q;
    done = state_q == ST_CS_HOLD && phase_end;
    div_d = (state_q == ST_IDLE || phase_end) ? '0 : div_q + 1'b1;
    sck_d = (state_q == ST_SHIFT && phase_end) ? !sck_q : sck_q;
    rx_d = rise ? {rx_q[RX_W-2:0], miso_q} : rx_q;
    tx_d = start ? CMD : fall ? tx_q << 1 : tx_q;
    bit_d = start ? '0 : fall ? bit_q + 1'b1 : bit_q;
    mosi_d = tx_d[FRAME_BITS-1];
    cs_d = start ? 1'b0 : done ? 1'b1 : cs_q;
    state_d = start ? ST_CS_SETUP
            : (state_q == ST_CS_SETUP && phase_end) ? ST_SHIFT
            : (fall && bit_q == CNT_W'(FRAME_BITS - 1)) ? ST_CS_HOLD
            : done ? ST_WRITE
            : state_q == ST_WRITE ? ST_IDLE
            : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q <= '0;
      bit_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      sck_q <= 1'b0;
      cs_q <= 1'b1;
      mosi_q <= 1'b0;
      miso_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      sck_q <= sck_d;
      cs_q <= cs_d;
      mosi_q <= mosi_d;
      miso_q <= miso_i;
    end
  end
  assign cs_o = cs_q;
  assign sck_o = sck_q;
  assign mosi_o = mosi_q;
  assign busy_o = state_q != ST_IDLE;
  assign done_o = done;
  assign sample_o = rx_q[RX_W-1:SAMPLE_LSB];
endmodule

// File: rtl/adc_sample_writer.sv
// adc_sample_writer: paced ADC sampling into ping-pong sample banks with bank-full pulse
module adc_sample_writer
  import adc_sample_writer_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int FRAME_BITS = 16,
  parameter logic [15:0] CMD_WORD = 16'h6000,
  parameter int SAMPLE_LSB = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  input  logic adc_miso,
  output logic adc_mosi,
  output logic adc_cs,
  output logic adc_sck,
  output logic write_request,
  output logic [SAMPLE_ADDR_W-1:0] write_address,
  output logic [SAMPLE_W-1:0] d_in,
  output logic bank_done,
  output logic done_bank,
  output logic overrun
);
  localparam int TMR_W = $clog2(SAMPLE_PERIOD);
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [SAMPLE_IDX_W-1:0] index_q, index_d;
  logic [SAMPLE_ADDR_W-1:0] addr_q, addr_d;
  logic [SAMPLE_W-1:0] din_q, din_d, sample;
  logic bank_q, bank_d, wr_q, wr_d, bd_q, bd_d, db_q, db_d, ovr_q, ovr_d;
  logic tick, busy, frame_done;
  spi_frame_engine #(
    .CLK_DIV(CLK_DIV),
    .FRAME_BITS(FRAME_BITS),
    .CMD_WORD(CMD_WORD),
    .SAMPLE_LSB(SAMPLE_LSB)
  ) u_engine (
    .clk(sys_clk),
    .rst(sys_rst),
    .start_i(tick),
    .miso_i(adc_miso),
    .cs_o(adc_cs),
    .sck_o(adc_sck),
    .mosi_o(adc_mosi),
    .busy_o(busy),
    .done_o(frame_done),
    .sample_o(sample)
  );
  assign tick = en && timer_q == TMR_W'(SAMPLE_PERIOD - 1);
  always_comb begin
    timer_d = (!en || tick) ? '0 : timer_q + 1'b1;
    ovr_d = ovr_q | (tick & busy);
    wr_d = frame_done;
    addr_d = frame_done ? {bank_q, index_q} : addr_q;
    din_d = frame_done ? sample : din_q;
    index_d = frame_done ? index_q + 1'b1 : index_q;
    bank_d = (frame_done && &index_q) ? !bank_q : bank_q;
    // bank_done follows the write of the last index by one cycle
    bd_d = wr_q && &addr_q[SAMPLE_IDX_W-1:0];
    db_d = bd_d ? addr_q[SAMPLE_ADDR_W-1] : db_q;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      timer_q <= '0;
      ovr_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
      index_q <= '0;
      bank_q <= 1'b0;
      bd_q <= 1'b0;
      db_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      ovr_q <= ovr_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      din_q <= din_d;
      index_q <= index_d;
      bank_q <= bank_d;
      bd_q <= bd_d;
      db_q <= db_d;
    end
  end
  assign write_request = wr_q;
  assign write_address = addr_q;
  assign d_in = din_q;
  assign bank_done = bd_q;
  assign done_bank = db_q;
  assign overrun = ovr_q;
endmodule
